// File: rtl/bist_sequencer_3x6.sv
// Self-test sequencer: flushes the core, applies LFSR patterns, compacts core
// outputs into a 16-bit MISR and compares the result with a golden signature.
module bist_sequencer_3x6 #(
  parameter int          FLUSH_CYCLES = 32,
  parameter int          NUM_PATTERNS = 256,
  parameter int          CAPTURE_LAT  = 1,
  parameter logic [7:0]  LFSR_SEED    = 8'h01,
  parameter logic [2:0]  FLUSH_VEC    = 3'b000,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  output logic [2:0]  dut_in,
  input  logic [5:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int MAX_FN  = (FLUSH_CYCLES > NUM_PATTERNS) ? FLUSH_CYCLES : NUM_PATTERNS;
  localparam int MAX_CNT = (MAX_FN > CAPTURE_LAT) ? MAX_FN : CAPTURE_LAT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((CAPTURE_LAT > 0) ? CAPTURE_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cap_en;
  logic [15:0]      misr_next;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {10'b0, d};
  endfunction

  assign lfsr_nxt  = lfsr_step(lfsr);
  assign misr_next = cap_en ? misr_step(signature, dut_out) : signature;

  // Capture enable: RUN flag delayed by the core latency so the sample that
  // matches each applied pattern is the one compacted.
  generate
    if (CAPTURE_LAT == 0) begin : g_cap_comb
      assign cap_en = (state == RUN);
    end else begin : g_cap_pipe
      logic [CAPTURE_LAT-1:0] run_vld_p;
      always_ff @(posedge CK) begin
        if (RST || abort)
          run_vld_p <= '0;
        else
          run_vld_p <= (run_vld_p << 1) | CAPTURE_LAT'(state == RUN);
      end
      assign cap_en = run_vld_p[CAPTURE_LAT-1];
    end
  endgenerate

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      dut_in    <= FLUSH_VEC;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      lfsr      <= LFSR_SEED;
      cnt       <= '0;
    end else if (abort) begin
      // Signature is intentionally left untouched for post-mortem inspection.
      state  <= IDLE;
      dut_in <= FLUSH_VEC;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      cnt    <= '0;
    end else begin
      signature <= misr_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FLUSH;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
            lfsr      <= LFSR_SEED;
            cnt       <= '0;
            dut_in    <= FLUSH_VEC;
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state  <= RUN;
            cnt    <= '0;
            dut_in <= lfsr[2:0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (cnt == RUN_LAST) begin
            cnt    <= '0;
            dut_in <= FLUSH_VEC;
            if (CAPTURE_LAT > 0) begin
              state <= DRAIN;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (misr_next == GOLDEN);
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            dut_in <= lfsr_nxt[2:0];
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_next == GOLDEN);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer_3x6.sv
// Directed bench for bist_sequencer_3x6: short config with a latency-1 core
// model, plus a zero-latency instance long enough to exercise MISR feedback.
module tb_bist_sequencer_3x6;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic        RST, start, abort, start2;
  logic [2:0]  dut_in, dut_in2;
  logic [5:0]  dut_out, dut_out2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [15:0] signature, signature2;

  logic        out_mode;
  logic [5:0]  out_const;
  logic [5:0]  core_q;

  int checks = 0;
  int errors = 0;

  // Latency-1 stand-in for the core: output mirrors last cycle's input.
  always_ff @(posedge CK) core_q <= {3'b000, dut_in};
  assign dut_out  = out_mode ? core_q : out_const;
  assign dut_out2 = 6'h01;

  bist_sequencer_3x6 #(
    .FLUSH_CYCLES(4), .NUM_PATTERNS(8), .CAPTURE_LAT(1),
    .LFSR_SEED(8'h01), .FLUSH_VEC(3'b000), .GOLDEN(16'h0000)
  ) dut (
    .CK(CK), .RST(RST), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  bist_sequencer_3x6 #(
    .FLUSH_CYCLES(2), .NUM_PATTERNS(20), .CAPTURE_LAT(0),
    .LFSR_SEED(8'h01), .FLUSH_VEC(3'b000), .GOLDEN(16'h0E10)
  ) dut2 (
    .CK(CK), .RST(RST), .start(start2), .abort(1'b0),
    .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(signature2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Launch and check completion at cycle 14 after the start edge.
  task automatic run_full(input string tag, input logic [15:0] exp_sig, input logic exp_pass);
    pulse_start();
    chk({tag, "_clr_done"}, {15'b0, done}, 16'd0);
    chk({tag, "_clr_sig"}, signature, 16'h0000);
    repeat (12) tick();
    chk({tag, "_c13_done"}, {15'b0, done}, 16'd0);
    tick();
    chk({tag, "_c14_done"}, {15'b0, done}, 16'd1);
    chk({tag, "_c14_busy"}, {15'b0, busy}, 16'd0);
    chk({tag, "_sig"}, signature, exp_sig);
    chk({tag, "_pass"}, {15'b0, pass}, {15'b0, exp_pass});
  endtask

  logic [2:0] run_vec [8];
  logic [2:0] exp_in;

  initial begin
    run_vec   = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7, 3'd6};
    RST       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    start2    = 1'b0;
    out_mode  = 1'b1;
    out_const = 6'h00;

    // T1 reset
    tick();
    tick();
    chk("rst_dut_in", {13'b0, dut_in}, 16'd0);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_pass", {15'b0, pass}, 16'd0);
    chk("rst_sig", signature, 16'h0000);
    chk("rst_sig2", signature2, 16'h0000);
    RST = 1'b0;
    tick();

    // T2 sequencing with the latency-1 core model
    pulse_start();
    for (int c = 1; c <= 13; c++) begin
      exp_in = (c >= 5 && c <= 12) ? run_vec[c-5] : 3'd0;
      chk($sformatf("seq_in_c%0d", c), {13'b0, dut_in}, {13'b0, exp_in});
      chk($sformatf("seq_busy_c%0d", c), {15'b0, busy}, 16'd1);
      chk($sformatf("seq_done_c%0d", c), {15'b0, done}, 16'd0);
      tick();
    end
    chk("seq_done_c14", {15'b0, done}, 16'd1);
    chk("seq_busy_c14", {15'b0, busy}, 16'd0);
    chk("seq_sig", signature, 16'h008C);
    chk("seq_pass", {15'b0, pass}, 16'd0);
    repeat (3) tick();
    chk("seq_hold_done", {15'b0, done}, 16'd1);
    chk("seq_hold_sig", signature, 16'h008C);

    // T3/T4 compaction with constant core outputs
    out_mode  = 1'b0;
    out_const = 6'h01;
    run_full("ones", 16'h00FF, 1'b0);
    out_const = 6'h00;
    run_full("zero", 16'h0000, 1'b1);

    // T5 abort and start together mid-RUN
    out_const = 6'h01;
    pulse_start();
    repeat (6) tick();
    chk("ab_pre_sig", signature, 16'h0001);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", {15'b0, busy}, 16'd0);
    chk("ab_done", {15'b0, done}, 16'd0);
    chk("ab_pass", {15'b0, pass}, 16'd0);
    chk("ab_sig", signature, 16'h0001);
    chk("ab_dut_in", {13'b0, dut_in}, 16'd0);
    repeat (2) tick();
    chk("ab_idle_busy", {15'b0, busy}, 16'd0);
    chk("ab_idle_sig", signature, 16'h0001);
    run_full("ab_rerun", 16'h00FF, 1'b0);

    // T6 RST mid-FLUSH, then start pulsed during RUN
    pulse_start();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_busy", {15'b0, busy}, 16'd0);
    chk("rst2_done", {15'b0, done}, 16'd0);
    chk("rst2_sig", signature, 16'h0000);
    chk("rst2_dut_in", {13'b0, dut_in}, 16'd0);
    out_mode = 1'b1;
    pulse_start();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("bs_c13_done", {15'b0, done}, 16'd0);
    chk("bs_c13_busy", {15'b0, busy}, 16'd1);
    tick();
    chk("bs_c14_done", {15'b0, done}, 16'd1);
    chk("bs_sig", signature, 16'h008C);

    // Zero-latency instance: 20 captures of 1 pass through MISR feedback
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (21) tick();
    chk("z_c22_done", {15'b0, done2}, 16'd0);
    chk("z_c22_busy", {15'b0, busy2}, 16'd1);
    tick();
    chk("z_c23_done", {15'b0, done2}, 16'd1);
    chk("z_c23_busy", {15'b0, busy2}, 16'd0);
    chk("z_sig", signature2, 16'h0E10);
    chk("z_pass", {15'b0, pass2}, 16'd1);
    chk("z_dut_in", {13'b0, dut_in2}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
